// File: rtl/ec_scalar_mul_k233_if.sv
// Result bus of the K-233 scalar multiplier.
//   key  : 32-bit scalar k (driven by the master, sampled by the core)
//   sx/sy: affine coordinates of k*G (driven by the core)
//   done : result valid, held until the next reset
interface ec_scalar_mul_k233_if;
   logic [31:0]  key;
   logic [232:0] sx;
   logic [232:0] sy;
   logic         done;

   modport master (output key, input sx, sy, done);
   modport slave  (input key, output sx, sy, done);
endinterface

// File: rtl/ec_scalar_mul_k233.sv
// Elliptic-curve scalar multiplier on sect233k1 (y^2 + xy = x^3 + 1 over
// GF(2^233), f(z) = z^233 + z^74 + 1). Computes Q = k*G for a 32-bit k,
// starting by itself when reset is released.
//   clk  : rising-edge clock
//   nrst : asynchronous reset, active HIGH despite the name
//   bus  : slave side of ec_scalar_mul_k233_if (key in, sx/sy/done out)
// Build option ECSMUL_CONST_TIME_EN: when defined, the ladder starts from
// (O,G) and walks all 32 key bits, so latency does not depend on the key.
// When undefined, LOAD scans for the leading 1 and the ladder starts below it.
// Datapath: 8-entry register file, digit-serial multiplier (DIGIT bits per
// cycle), one-cycle squarer; a small micro-program sequences the ladder step,
// the inversion and the affine recovery.
module ec_scalar_mul_k233 #(
   parameter int           M     = 233,
   parameter int           DIGIT = 8,
   parameter logic [M-1:0] GX    = 233'h17232BA853A7E731AF129F22FF4149563A419C26BF50A4C9D6EEFAD6126,
   parameter logic [M-1:0] GY    = 233'h1DB537DECE819B7F70F555A67C427A8CD9BF18AEB9B56E0C11056FAE6A3
) (
   input logic                  clk,
   input logic                  nrst,
   ec_scalar_mul_k233_if.slave  bus
);
   localparam int NDIG = (M + DIGIT - 1) / DIGIT;
   localparam int BP   = NDIG * DIGIT;
   localparam logic [M-1:0] RED = {158'd0, 1'b1, 73'd0, 1'b1};   // z^74 + 1
   localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};
   // source selectors above the register file
   localparam int GXS = 8, GYS = 9, CS = 10, ZS = 11;
   localparam logic [5:0] LAD_PC = 6'd0, INV_PC = 6'd16;

   typedef enum logic [2:0] {IDLE, LOAD, LADDER, INV, AFFINE, DONE} state_t;
   typedef enum logic [2:0] {OP_ADD, OP_SQR, OP_MUL, OP_CSW, OP_END} op_t;
   typedef struct packed {
      op_t        op;
      logic [2:0] rd;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [7:0] n;     // squaring repeat count
   } uop_t;

   function automatic uop_t mk(input op_t op, input int rd, input int ra, input int rb, input int n);
      uop_t u;
      u.op = op; u.rd = 3'(rd); u.ra = 4'(ra); u.rb = 4'(rb); u.n = 8'(n);
      return u;
   endfunction

   // r0..r3 = X1,Z1,X2,Z2 ; r4..r7 scratch.
   // Ladder step computes P1<-madd, P2<-double; the conditional swaps around it
   // map bit=0 onto the same routing, so both bit values cost the same cycles.
   // The inversion is folded: D = GX*Z1*Z2 is inverted once (Itoh-Tsujii chain
   // 1,2,3,6,7,14,28,29,58,116,232 then one squaring), and both 1/Z1 and the
   // y-quotient are derived from D^-1.
   function automatic uop_t urom(input logic [5:0] a);
      uop_t u;
      u = mk(OP_END, 0, 0, 0, 0);
      case (a)
         6'd0:  u = mk(OP_CSW, 0, 0, 0, 0);
         6'd1:  u = mk(OP_MUL, 4, 0, 3, 0);      // X1*Z2
         6'd2:  u = mk(OP_MUL, 5, 2, 1, 0);      // X2*Z1
         6'd3:  u = mk(OP_ADD, 1, 4, 5, 0);
         6'd4:  u = mk(OP_SQR, 1, 1, 0, 1);      // Z1 = (..)^2
         6'd5:  u = mk(OP_MUL, 4, 4, 5, 0);
         6'd6:  u = mk(OP_MUL, 0, GXS, 1, 0);
         6'd7:  u = mk(OP_ADD, 0, 0, 4, 0);      // X1
         6'd8:  u = mk(OP_SQR, 4, 2, 0, 1);      // X2^2
         6'd9:  u = mk(OP_SQR, 5, 3, 0, 1);      // Z2^2
         6'd10: u = mk(OP_MUL, 3, 4, 5, 0);      // Z2
         6'd11: u = mk(OP_SQR, 4, 4, 0, 1);
         6'd12: u = mk(OP_SQR, 5, 5, 0, 1);
         6'd13: u = mk(OP_ADD, 2, 4, 5, 0);      // X2 = X^4 + Z^4
         6'd14: u = mk(OP_CSW, 0, 0, 0, 0);
         6'd15: u = mk(OP_END, 0, 0, 0, 0);
         6'd16: u = mk(OP_MUL, 4, 1, 3, 0);      // Z1*Z2
         6'd17: u = mk(OP_MUL, 5, GXS, 4, 0);    // D
         6'd18: u = mk(OP_ADD, 6, 5, ZS, 0);
         6'd19: u = mk(OP_SQR, 7, 6, 0, 1);   6'd20: u = mk(OP_MUL, 6, 7, 6, 0);
         6'd21: u = mk(OP_SQR, 7, 6, 0, 1);   6'd22: u = mk(OP_MUL, 6, 7, 5, 0);
         6'd23: u = mk(OP_SQR, 7, 6, 0, 3);   6'd24: u = mk(OP_MUL, 6, 7, 6, 0);
         6'd25: u = mk(OP_SQR, 7, 6, 0, 1);   6'd26: u = mk(OP_MUL, 6, 7, 5, 0);
         6'd27: u = mk(OP_SQR, 7, 6, 0, 7);   6'd28: u = mk(OP_MUL, 6, 7, 6, 0);
         6'd29: u = mk(OP_SQR, 7, 6, 0, 14);  6'd30: u = mk(OP_MUL, 6, 7, 6, 0);
         6'd31: u = mk(OP_SQR, 7, 6, 0, 1);   6'd32: u = mk(OP_MUL, 6, 7, 5, 0);
         6'd33: u = mk(OP_SQR, 7, 6, 0, 29);  6'd34: u = mk(OP_MUL, 6, 7, 6, 0);
         6'd35: u = mk(OP_SQR, 7, 6, 0, 58);  6'd36: u = mk(OP_MUL, 6, 7, 6, 0);
         6'd37: u = mk(OP_SQR, 7, 6, 0, 116); 6'd38: u = mk(OP_MUL, 6, 7, 6, 0);
         6'd39: u = mk(OP_SQR, 6, 6, 0, 1);      // D^-1
         6'd40: u = mk(OP_END, 0, 0, 0, 0);
         6'd41: u = mk(OP_MUL, 7, 6, 3, 0);
         6'd42: u = mk(OP_MUL, 7, 7, GXS, 0);    // 1/Z1
         6'd43: u = mk(OP_MUL, 7, 0, 7, 0);      // x
         6'd44: u = mk(OP_MUL, 5, GXS, 1, 0);
         6'd45: u = mk(OP_ADD, 5, 5, 0, 0);      // X1 + GX*Z1
         6'd46: u = mk(OP_MUL, 1, GXS, 3, 0);
         6'd47: u = mk(OP_ADD, 1, 1, 2, 0);      // X2 + GX*Z2
         6'd48: u = mk(OP_MUL, 5, 5, 1, 0);
         6'd49: u = mk(OP_MUL, 1, CS, 4, 0);     // (GX^2+GY)*Z1*Z2
         6'd50: u = mk(OP_ADD, 5, 5, 1, 0);
         6'd51: u = mk(OP_MUL, 5, 5, 6, 0);      // N / D
         6'd52: u = mk(OP_ADD, 1, 7, GXS, 0);
         6'd53: u = mk(OP_MUL, 5, 5, 1, 0);
         6'd54: u = mk(OP_ADD, 5, 5, GYS, 0);    // y
         default: u = mk(OP_END, 0, 0, 0, 0);
      endcase
      return u;
   endfunction

   function automatic logic [M-1:0] mulz(input logic [M-1:0] v);
      return {v[M-2:0], 1'b0} ^ (v[M-1] ? RED : '0);
   endfunction

   function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
      logic [2*M-2:0] w;
      w = '0;
      for (int j = 0; j < M; j++) w[2*j] = a[j];
      for (int j = 2*M-2; j >= M; j--)
         if (w[j]) begin
            w[j-M]    = ~w[j-M];
            w[j-M+74] = ~w[j-M+74];
         end
      return w[M-1:0];
   endfunction

   // one Horner digit, MSB first: acc*z^DIGIT + a*d
   function automatic logic [M-1:0] mstep(input logic [M-1:0] acc, input logic [M-1:0] a,
                                          input logic [DIGIT-1:0] d);
      logic [M-1:0] t;
      t = acc;
      for (int j = DIGIT-1; j >= 0; j--) t = mulz(t) ^ (d[j] ? a : '0);
      return t;
   endfunction

   state_t       state;
   logic [5:0]   pc;
   logic [7:0]   rep, mcnt;
   logic [4:0]   i;
   logic [31:0]  kreg;
   logic         zflag, mbusy, done_q;
   logic [M-1:0] r [8];
   logic [M-1:0] acc, ma, sx_q, sy_q;
   logic [BP-1:0] mb;
   logic [M-1:0] gx2, cgy, va, vb, sqv, mres;
   uop_t         u;

   assign gx2 = gf_sq(GX);
   assign cgy = gx2 ^ GY;

   function automatic logic [M-1:0] src(input logic [3:0] s);
      case (s)
         4'd8:    return GX;
         4'd9:    return GY;
         4'd10:   return cgy;
         4'd11:   return '0;
         default: return r[s[2:0]];
      endcase
   endfunction

   always_comb begin
      u    = urom(pc);
      va   = src(u.ra);
      vb   = src(u.rb);
      sqv  = gf_sq(rep == 8'd0 ? va : r[u.rd]);
      mres = mstep(acc, ma, mb[BP-1 -: DIGIT]);
   end

   assign bus.sx   = sx_q;
   assign bus.sy   = sy_q;
   assign bus.done = done_q;

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         state <= IDLE; pc <= '0; rep <= '0; mcnt <= '0; i <= '0; kreg <= '0;
         zflag <= 1'b0; mbusy <= 1'b0; done_q <= 1'b0;
         acc <= '0; ma <= '0; mb <= '0; sx_q <= '0; sy_q <= '0;
         for (int j = 0; j < 8; j++) r[j] <= '0;
      end else begin
         case (state)
            IDLE: begin
               kreg  <= bus.key;
               i     <= 5'd31;
               state <= LOAD;
            end
            LOAD: begin
`ifdef ECSMUL_CONST_TIME_EN
               // (O,G) start: O is (1,0) in projective form
               r[0] <= ONE; r[1] <= '0; r[2] <= GX; r[3] <= ONE;
               pc <= LAD_PC; state <= LADDER;
`else
               if (kreg[i]) begin
                  r[0] <= GX; r[1] <= ONE; r[2] <= gf_sq(gx2) ^ ONE; r[3] <= gx2;   // (G,2G)
                  if (i == 5'd0) begin
                     pc <= INV_PC; state <= INV;
                  end else begin
                     i <= i - 5'd1; pc <= LAD_PC; state <= LADDER;
                  end
               end else if (i == 5'd0) begin
                  done_q <= 1'b1; state <= DONE;     // key = 0
               end else begin
                  i <= i - 5'd1;
               end
`endif
            end
            LADDER, INV, AFFINE: begin
               case (u.op)
                  OP_ADD: begin
                     r[u.rd] <= va ^ vb; pc <= pc + 6'd1;
                  end
                  OP_SQR: begin
                     r[u.rd] <= sqv;
                     if (rep == u.n - 8'd1) begin rep <= '0; pc <= pc + 6'd1; end
                     else rep <= rep + 8'd1;
                  end
                  OP_MUL: begin
                     if (!mbusy) begin
                        ma <= va; mb <= BP'(vb); acc <= '0; mcnt <= '0; mbusy <= 1'b1;
                     end else begin
                        acc  <= mres;
                        mb   <= mb << DIGIT;
                        mcnt <= mcnt + 8'd1;
                        if (mcnt == 8'(NDIG - 1)) begin
                           r[u.rd] <= mres; mbusy <= 1'b0; pc <= pc + 6'd1;
                        end
                     end
                  end
                  OP_CSW: begin
                     if (!kreg[i]) begin
                        r[0] <= r[2]; r[1] <= r[3]; r[2] <= r[0]; r[3] <= r[1];
                     end
                     pc <= pc + 6'd1;
                  end
                  default: begin
                     if (state == LADDER) begin
                        if (i == 5'd0) begin
                           zflag <= (r[1] == '0);    // k*G is the point at infinity
                           pc <= INV_PC; state <= INV;
                        end else begin
                           i <= i - 5'd1; pc <= LAD_PC;
                        end
                     end else if (state == INV) begin
                        pc <= pc + 6'd1; state <= AFFINE;
                     end else begin
                        sx_q   <= zflag ? '0 : r[7];
                        sy_q   <= zflag ? '0 : r[5];
                        done_q <= 1'b1;
                        state  <= DONE;
                     end
                  end
               endcase
            end
            default: ;   // DONE: hold until reset
         endcase
      end
   end
endmodule

// File: tb/tb_ec_scalar_mul_k233.sv
module tb_ec_scalar_mul_k233;
   typedef logic [232:0] fe_t;
   typedef struct { logic inf; fe_t x; fe_t y; } pt_t;
   typedef struct packed { fe_t x; fe_t y; } pair_t;

   localparam fe_t GX = 233'h17232BA853A7E731AF129F22FF4149563A419C26BF50A4C9D6EEFAD6126;
   localparam fe_t GY = 233'h1DB537DECE819B7F70F555A67C427A8CD9BF18AEB9B56E0C11056FAE6A3;
   localparam int  LIMIT = 20000;

   logic clk = 1'b0;
   logic nrst = 1'b1;
   ec_scalar_mul_k233_if bus();
   ec_scalar_mul_k233 dut (.clk(clk), .nrst(nrst), .bus(bus));
   always #5 clk = ~clk;

   int    errors = 0, checks = 0;
   pair_t sb[$];

   // ---- reference field / curve model (affine, LSB-first multiply, Fermat inverse)
   function automatic fe_t m_mul(input fe_t a, input fe_t b);
      fe_t res = '0;
      fe_t red = '0;
      red[74] = 1'b1; red[0] = 1'b1;
      for (int k = 0; k < 233; k++) begin
         if (b[k]) res ^= a;
         a = a[232] ? ({a[231:0], 1'b0} ^ red) : {a[231:0], 1'b0};
      end
      return res;
   endfunction

   function automatic fe_t m_inv(input fe_t a);
      fe_t t = a;
      fe_t res = fe_t'(1);
      for (int k = 0; k < 232; k++) begin
         t = m_mul(t, t);
         res = m_mul(res, t);
      end
      return res;
   endfunction

   function automatic pt_t p_dbl(input pt_t p);
      pt_t q; fe_t l;
      q.inf = 1'b1; q.x = '0; q.y = '0;
      if (p.inf || p.x == '0) return q;
      l = p.x ^ m_mul(p.y, m_inv(p.x));
      q.inf = 1'b0;
      q.x = m_mul(l, l) ^ l;
      q.y = m_mul(p.x, p.x) ^ m_mul(l ^ fe_t'(1), q.x);
      return q;
   endfunction

   function automatic pt_t p_add(input pt_t p, input pt_t q);
      pt_t s; fe_t l;
      if (p.inf) return q;
      if (q.inf) return p;
      if (p.x == q.x) begin
         if (p.y == q.y) return p_dbl(p);
         s.inf = 1'b1; s.x = '0; s.y = '0;
         return s;
      end
      l = m_mul(p.y ^ q.y, m_inv(p.x ^ q.x));
      s.inf = 1'b0;
      s.x = m_mul(l, l) ^ l ^ p.x ^ q.x;
      s.y = m_mul(l, p.x ^ s.x) ^ s.x ^ p.y;
      return s;
   endfunction

   function automatic pair_t model(input logic [31:0] k);
      pt_t acc, g;
      pair_t e;
      acc.inf = 1'b1; acc.x = '0; acc.y = '0;
      g.inf = 1'b0; g.x = GX; g.y = GY;
      for (int b = 31; b >= 0; b--) begin
         acc = p_dbl(acc);
         if (k[b]) acc = p_add(acc, g);
      end
      e.x = acc.inf ? '0 : acc.x;
      e.y = acc.inf ? '0 : acc.y;
      return e;
   endfunction

   function automatic fe_t curve_lhs(input fe_t x, input fe_t y);
      return m_mul(y, y) ^ m_mul(x, y) ^ m_mul(m_mul(x, x), x);
   endfunction

   // ---- checking helpers
   task automatic chk(input string tag, input fe_t obs, input fe_t expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic pulse(input logic [31:0] k);
      @(negedge clk);
      bus.key = k;
      nrst = 1'b1;
      repeat (2) @(negedge clk);
      nrst = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int lat);
      lat = 0;
      while (bus.done !== 1'b1 && lat < LIMIT) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " done"}, fe_t'(bus.done), fe_t'(1));
   endtask

   task automatic pop_chk(input string tag);
      pair_t e;
      e = sb.pop_front();
      chk({tag, " sx"}, bus.sx, e.x);
      chk({tag, " sy"}, bus.sy, e.y);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, " sx"}, bus.sx, '0);
      chk({tag, " sy"}, bus.sy, '0);
      chk({tag, " done"}, fe_t'(bus.done), '0);
   endtask

   initial begin
      int    lat1, lat0, lat2, latf, lat3, lat1b;
      pair_t ef;
      bus.key = '0;
      repeat (2) @(negedge clk);
      chk_cleared("reset");

      // k = 1 -> G exactly
      sb.push_back(model(32'h1));
      pulse(32'h1);
      wait_done("k1", lat1);
      pop_chk("k1");
      chk("k1 gx", bus.sx, GX);
      chk("k1 gy", bus.sy, GY);

      // k = 0 -> point at infinity reported as (0,0)
      sb.push_back(model(32'h0));
      pulse(32'h0);
      wait_done("k0", lat0);
      pop_chk("k0");

      // k = 2 -> 2G, and the result lies on the curve
      sb.push_back(model(32'h2));
      pulse(32'h2);
      wait_done("k2", lat2);
      pop_chk("k2");
      chk("k2 curve", curve_lhs(bus.sx, bus.sy), fe_t'(1));

      // long key, result held afterwards
      ef = model(32'hFFFF0000);
      sb.push_back(ef);
      pulse(32'hFFFF0000);
      wait_done("kF", latf);
      pop_chk("kF");
      repeat (100) @(negedge clk);
      chk("kF hold done", fe_t'(bus.done), fe_t'(1));
      chk("kF hold sx", bus.sx, ef.x);
      chk("kF hold sy", bus.sy, ef.y);

      // asynchronous clear between clock edges
      @(negedge clk);
      #2 nrst = 1'b1;
      #1 chk_cleared("async rst");

      // key changes after LOAD are ignored
      sb.push_back(model(32'h3));
      pulse(32'h3);
      repeat (200) @(negedge clk);
      bus.key = 32'h5;
      wait_done("k3 chg", lat3);
      pop_chk("k3 chg");

      // abort in the middle of the ladder, then restart with k = 1
      pulse(32'hFFFF0000);
      repeat (500) @(negedge clk);
      #2 nrst = 1'b1;
      #1 chk_cleared("mid abort");
      sb.push_back(model(32'h1));
      pulse(32'h1);
      wait_done("k1 again", lat1b);
      pop_chk("k1 again");

`ifdef ECSMUL_CONST_TIME_EN
      chk("lat k2", fe_t'(lat2), fe_t'(lat1));
      chk("lat kF", fe_t'(latf), fe_t'(lat1));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
